// File: rtl/tanh_pkg.sv
// Shared constants and payload types for the tanh input-quantisation path.
// The sample format is Q4.8 and the downstream core takes a Q2.4 index.
package tanh_pkg;

  localparam int TANH_IN_W     = 12;
  localparam int TANH_IN_FRAC  = 8;
  localparam int TANH_IDX_W    = 6;
  localparam int TANH_IDX_FRAC = 4;
  localparam int TANH_IDX_MAX  = 63;

  // Quantised magnitude with its sign, reused by the sign-restore stage.
  typedef struct packed {
    logic                  sign;
    logic [TANH_IDX_W-1:0] idx;
    logic                  sat;
  } tanh_q_t;

endpackage

// File: rtl/tanh_pipe_slice.sv
// Generic valid/ready register slice. The slice holds its payload while
// full and not drained, and loads when empty or draining in the same cycle.
// ready_o is combinational from ready_i so a full pipe can still stream.
module tanh_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load_s;

  assign ready_o = ~valid_q | ready_i;
  assign load_s  = valid_i & ready_o;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next-state: load new payload, drain to empty, or hold while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice state register with synchronous reset to an empty, zeroed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/tanh_in_quant.sv
// Input quantiser for the tanh approximation unit.
// S1 splits a Q4.8 sample into sign and magnitude; S2 rescales the magnitude
// to a Q2.4 index with saturation at 63. A saturating counter tracks how many
// clamped samples have left the block.
// Build option TANH_IN_QUANT_ROUND_EN: round-half-up on the magnitude before
// the rescale instead of truncating; timing and handshake are unchanged.
module tanh_in_quant
  import tanh_pkg::*;
#(
  parameter int IN_W     = TANH_IN_W,
  parameter int IN_FRAC  = TANH_IN_FRAC,
  parameter int IDX_W    = TANH_IDX_W,
  parameter int IDX_FRAC = TANH_IDX_FRAC,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sign,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // One extra bit so that the most negative input has a representable magnitude.
  localparam int MAG_W   = IN_W + 1;
  localparam int SHIFT   = IN_FRAC - IDX_FRAC;
  localparam int IDX_MAX = TANH_IDX_MAX;
  localparam int S1_W    = MAG_W + 1;
  localparam int S2_W    = $bits(tanh_q_t);

  logic             s1_sign_s;
  logic [MAG_W-1:0] s1_ext_s;
  logic [MAG_W-1:0] s1_mag_s;

  logic             s1_valid_s;
  logic             s1_ready_s;
  logic [S1_W-1:0]  s1_data_s;
  logic             s1_sign_q;
  logic [MAG_W-1:0] s1_mag_q;

  logic [MAG_W-1:0] s2_sum_s;
  logic [MAG_W-1:0] s2_r_s;
  logic [IDX_W-1:0] s2_idx_s;
  logic             s2_sat_s;
  logic             s2_sign_s;
  tanh_q_t          s2_in_s;
  logic [S2_W-1:0]  s2_data_s;
  tanh_q_t          s2_q;

  logic [CNT_W-1:0] sat_cnt_q;
  logic [CNT_W-1:0] sat_cnt_d;
  logic             out_fire_s;

  // Sign/magnitude split of the incoming two's-complement sample.
  always_comb begin
    s1_sign_s = in_data[IN_W-1];
    s1_ext_s  = {in_data[IN_W-1], in_data};
    if (s1_sign_s) begin
      s1_mag_s = ~s1_ext_s + MAG_W'(1);
    end else begin
      s1_mag_s = s1_ext_s;
    end
  end

  tanh_pipe_slice #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  ({s1_sign_s, s1_mag_s}),
    .valid_o (s1_valid_s),
    .ready_i (s1_ready_s),
    .data_o  (s1_data_s)
  );

  assign s1_sign_q = s1_data_s[S1_W-1];
  assign s1_mag_q  = s1_data_s[MAG_W-1:0];

`ifdef TANH_IN_QUANT_ROUND_EN
  localparam int RND = 1 << (SHIFT - 1);

  // Round-half-up: add half an output LSB before the rescale.
  always_comb begin
    s2_sum_s = s1_mag_q + MAG_W'(RND);
  end
`else
  // Truncating rescale: magnitude passes straight to the shift.
  always_comb begin
    s2_sum_s = s1_mag_q;
  end
`endif

  // Rescale to the index grid, clamp to the top code, suppress negative zero.
  always_comb begin
    s2_r_s = s2_sum_s >> SHIFT;
    if (s2_r_s > MAG_W'(IDX_MAX)) begin
      s2_idx_s = IDX_W'(IDX_MAX);
      s2_sat_s = 1'b1;
    end else begin
      s2_idx_s = s2_r_s[IDX_W-1:0];
      s2_sat_s = 1'b0;
    end
    s2_sign_s = s1_sign_q & (s2_idx_s != {IDX_W{1'b0}});
  end

  assign s2_in_s = '{sign: s2_sign_s, idx: s2_idx_s, sat: s2_sat_s};

  tanh_pipe_slice #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid_s),
    .ready_o (s1_ready_s),
    .data_i  (s2_in_s),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_data_s)
  );

  assign s2_q     = tanh_q_t'(s2_data_s);
  assign out_idx  = s2_q.idx;
  assign out_sign = s2_q.sign;
  assign out_sat  = s2_q.sat;

  assign out_fire_s = out_valid & out_ready;

  // Saturation counter next-state: clear has priority, count sticks at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = {CNT_W{1'b0}};
    end else if (out_fire_s && out_sat && (sat_cnt_q != {CNT_W{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_tanh_in_quant.sv
// Scoreboard bench for tanh_in_quant: accepted samples push an expected
// result computed with plain integer arithmetic; a negedge monitor pops and
// compares on every output handshake and tracks the saturation count.
module tb_tanh_in_quant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = 12'h000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_idx;
  logic        out_sign;
  logic        out_sat;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;

  tanh_in_quant dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_sign  (out_sign),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit neg;
    bit sat;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   ready_mode = 0;
  bit   lat_chk = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_idx = 0;
  bit   prev_sign = 1'b0;
  bit   prev_sat = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: |x| in units of 1/256, rescaled to units of 1/16, clamped at 63.
  function automatic exp_t ref_model(input logic [11:0] d, input int c);
    int v;
    int m;
    int r;
    exp_t e;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
`ifdef TANH_IN_QUANT_ROUND_EN
    r = (m + 8) / 16;
`else
    r = m / 16;
`endif
    e.sat = (r > 63);
    e.idx = e.sat ? 63 : r;
    e.neg = (v < 0) && (e.idx != 0);
    e.cyc = c;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern: 0 = always ready, 1 = random, 2 = held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    bit   fire_out;
    bit   exp_sat;
    chk("sat_cnt", int'(sat_cnt), model_cnt);
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      model_cnt  = 0;
    end else begin
      chk("in_ready", int'(in_ready), (q.size() >= 2 && !out_ready) ? 0 : 1);
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_idx", int'(out_idx), prev_idx);
        chk("stall_sign", int'(out_sign), int'(prev_sign));
        chk("stall_sat", int'(out_sat), int'(prev_sat));
      end
      fire_out = out_valid && out_ready;
      exp_sat  = 1'b0;
      if (fire_out) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          exp_sat = e.sat;
          chk("idx", int'(out_idx), e.idx);
          chk("sign", int'(out_sign), int'(e.neg));
          chk("sat", int'(out_sat), int'(e.sat));
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (sat_clr) model_cnt = 0;
      else if (fire_out && exp_sat && model_cnt < 65535) model_cnt = model_cnt + 1;
      if (in_valid && in_ready) q.push_back(ref_model(in_data, cyc));
      prev_stall = out_valid && !out_ready;
      prev_idx   = int'(out_idx);
      prev_sign  = out_sign;
      prev_sat   = out_sat;
    end
  end

  // Offer one sample until accepted; entered and left at posedge+1.
  task automatic send(input logic [11:0] d);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(2);
    chk("drain_empty", q.size(), 0);
  endtask

  logic [11:0] directed [8] = '{12'h100, 12'hE80, 12'h7FF, 12'h800,
                                12'h000, 12'hFFF, 12'h018, 12'h3F8};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_sign", int'(out_sign), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed values with a free-running sink, latency checked
    lat_chk = 1'b1;
    foreach (directed[i]) send(directed[i]);
    drain();

    // Clear coincident with a saturated handshake
    send(12'h7FF);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_wait", int'(out_valid), 1);
    sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", int'(sat_cnt), 0);
    @(posedge clk);
    #1;
    lat_chk = 1'b0;

    // Backpressure stream 0x010..0x0F0
    ready_mode = 1;
    for (int k = 1; k <= 15; k++) begin
      idle($urandom_range(0, 2));
      send(12'(k * 16));
    end
    drain();

    // Random samples under random flow control
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(12'($urandom));
    end
    drain();

    // Reset with two samples in flight
    ready_mode = 2;
    idle(1);
    send(12'h7FF);
    send(12'h100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sat_cnt", int'(sat_cnt), 0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(12'h100);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    errs++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
